// File: rtl/rns_conv_arbiter.sv
// rtl/rns_conv_arbiter.sv - round-robin arbiter sharing one int->RNS and one RNS->int converter
// Purpose: N_REQ requesters compete for a single conversion datapath. One operation is in
//   flight at a time: accept (IDLE or RESP) -> CONV (convert, register result) -> RESP.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_op                per requester: 0 = int->RNS, 1 = RNS->int
//   req_data              32-bit operand per requester, requester i at [32*i+:32]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_op        requester index and op of the response
//   rsp_data, rsp_err     converted value; err flags an out-of-range residue
//   conv_count            number of completed responses, wraps at 2^32
module rns_conv_arbiter #(
  parameter int          N_REQ = 4,
  parameter int unsigned B0    = 251,
  parameter int unsigned B1    = 241,
  parameter int unsigned B2    = 239,
  parameter int unsigned B3    = 233,
  localparam int         IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_op,
  input  logic [32*N_REQ-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_op,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic [31:0]        conv_count
);

  // Dynamic range of the residue system and the signed mapping around it.
  localparam logic [63:0] M_ALL = 64'(B0) * 64'(B1) * 64'(B2) * 64'(B3);
  // Negative 32-bit integers (x[31]=1) are folded into the top of [0, M_ALL).
  localparam logic [31:0] INT_RNS_DELTA    = 32'(64'h1_0000_0000 - M_ALL);
  localparam logic [31:0] RNS_MIDDLE_POINT = 32'((M_ALL + 64'd1) >> 1);

  // CRT basis element: (M/bj) * ((M/bj)^-1 mod bj); it is 1 mod bj and 0 mod the others.
  function automatic logic [63:0] crt_coeff(input logic [63:0] bj);
    logic [63:0] mj;
    logic [63:0] inv;
    mj  = M_ALL / bj;
    inv = 64'd0;
    for (int k = 1; k < 256; k++) begin
      if (inv == 64'd0 && (((mj % bj) * 64'(k)) % bj) == 64'd1) inv = 64'(k);
    end
    return mj * inv;
  endfunction

  localparam logic [63:0] E0 = crt_coeff(64'(B0));
  localparam logic [63:0] E1 = crt_coeff(64'(B1));
  localparam logic [63:0] E2 = crt_coeff(64'(B2));
  localparam logic [63:0] E3 = crt_coeff(64'(B3));

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             op_q, op_d;
  logic [31:0]      opd_q, opd_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_op_q, rsp_op_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      conv_count_q, conv_count_d;

  logic             accept_en;
  logic             found;
  logic             accept;
  logic [IDW-1:0]   grant_idx;

  logic [31:0]      x_shift;
  logic [31:0]      fwd_data;
  logic [63:0]      crt_sum;
  logic [31:0]      crt_val;
  logic [31:0]      rev_data;
  logic             rev_err;

  // Round-robin arbitration; gated off while reset is held so nothing is offered.
  always_comb begin
    int cand;
    accept_en = !rst && (state_q == IDLE || (state_q == RESP && rsp_ready));
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req_valid[IDW'(cand)]) begin
        found     = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
    accept    = accept_en && found;
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Converters operate on the latched operand during CONV.
  always_comb begin
    x_shift  = opd_q[31] ? (opd_q - INT_RNS_DELTA) : opd_q;
    fwd_data = {8'(x_shift % B3), 8'(x_shift % B2), 8'(x_shift % B1), 8'(x_shift % B0)};
    crt_sum  = 64'(opd_q[7:0]) * E0 + 64'(opd_q[15:8]) * E1
             + 64'(opd_q[23:16]) * E2 + 64'(opd_q[31:24]) * E3;
    crt_val  = 32'(crt_sum % M_ALL);
    rev_data = (crt_val >= RNS_MIDDLE_POINT) ? (crt_val + INT_RNS_DELTA) : crt_val;
    rev_err  = (opd_q[7:0] >= 8'(B0)) || (opd_q[15:8] >= 8'(B1))
            || (opd_q[23:16] >= 8'(B2)) || (opd_q[31:24] >= 8'(B3));
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_d         = op_q;
    opd_d        = opd_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_op_d     = rsp_op_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    conv_count_d = conv_count_q;
    case (state_q)
      IDLE: if (accept) state_d = CONV;
      CONV: begin
        state_d    = RESP;
        rsp_id_d   = id_q;
        rsp_op_d   = op_q;
        rsp_data_d = op_q ? rev_data : fwd_data;
        rsp_err_d  = op_q ? rev_err : 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          conv_count_d = conv_count_q + 32'd1;
          state_d      = accept ? CONV : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d     = req_op[grant_idx];
      opd_d    = req_data[{grant_idx, 5'b00000} +: 32];
      id_d     = grant_idx;
      rr_ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_q         <= 1'b0;
      opd_q        <= '0;
      id_q         <= '0;
      rsp_id_q     <= '0;
      rsp_op_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      conv_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_q         <= op_d;
      opd_q        <= opd_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_op_q     <= rsp_op_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      conv_count_q <= conv_count_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign conv_count = conv_count_q;

endmodule
